// File: rtl/scaled_framebuffer.sv
// ============================================================================
// Module      : scaled_framebuffer
// Description : Pixel store whose reads are downscaled by SCALE_SHIFT, with
//               clear sweeps and optional double buffering enabled by the
//               macro SCALED_FRAMEBUFFER_DOUBLE_BUFFER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scaled_framebuffer #(
    parameter int H_RES                    = 320,
    parameter int V_RES                    = 240,
    parameter int PIX_W                    = 8,
    parameter int COORD_W                  = 11,
    parameter int SCALE_SHIFT              = 1,
    parameter logic [PIX_W-1:0] CLEAR_VALUE  = '1,
    parameter logic [PIX_W-1:0] BORDER_VALUE = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               write_enable,
    input  logic [PIX_W-1:0]   data_in,
    input  logic [COORD_W-1:0] data_in_x,
    input  logic [COORD_W-1:0] data_in_y,
    input  logic               read_enable,
    input  logic [COORD_W-1:0] data_out_x,
    input  logic [COORD_W-1:0] data_out_y,
    output logic [PIX_W-1:0]   data_out,
    output logic               data_out_valid,
    input  logic               clear_req,
    output logic               busy,
    input  logic               swap_req,
    output logic               front_sel
);

    localparam int DEPTH  = H_RES * V_RES;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [COORD_W:0]   H_LIM     = (COORD_W + 1)'(H_RES);
    localparam logic [COORD_W:0]   V_LIM     = (COORD_W + 1)'(V_RES);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   sweep_addr;
    logic                sweep_last;
    logic                sweep_wr;
    logic                pix_wr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [COORD_W-1:0]  sx;
    logic [COORD_W-1:0]  sy;
    logic                rd_in_range;
    logic [ADDR_W-1:0]   rd_addr;
    logic [PIX_W-1:0]    rd_word;

    // ------------------------------------------------------------------
    // Sweep / idle control
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (sweep_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    // Held at 0 in IDLE so a new sweep always starts from the first word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sweep_addr <= '0;
        end else if (state == CLEAR) begin
            sweep_addr <= sweep_addr + ADDR_W'(1);
        end else begin
            sweep_addr <= '0;
        end
    end

    assign sweep_last = (sweep_addr == LAST_ADDR);
    assign sweep_wr   = reset && (state == CLEAR);
    assign pix_wr     = (state == IDLE) && write_enable
                        && ({1'b0, data_in_x} < H_LIM)
                        && ({1'b0, data_in_y} < V_LIM);
    assign wr_addr    = ADDR_W'(32'(data_in_y) * H_RES + 32'(data_in_x));

    assign sx          = data_out_x >> SCALE_SHIFT;
    assign sy          = data_out_y >> SCALE_SHIFT;
    assign rd_in_range = ({1'b0, sx} < H_LIM) && ({1'b0, sy} < V_LIM);
    assign rd_addr     = ADDR_W'(32'(sy) * H_RES + 32'(sx));

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
`ifdef SCALED_FRAMEBUFFER_DOUBLE_BUFFER_EN
    logic [PIX_W-1:0] bank0 [DEPTH];
    logic [PIX_W-1:0] bank1 [DEPTH];
    logic             swap_pending;
    logic             sweep_all;
    logic             back_sel;

    assign back_sel = ~front_sel;

    // The post-reset sweep covers both banks; later sweeps only the back one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            sweep_all    <= 1'b1;
        end else if (state == CLEAR) begin
            if (swap_req) begin
                swap_pending <= 1'b1;
            end
            if (sweep_last) begin
                sweep_all <= 1'b0;
            end
        end else if (swap_req || swap_pending) begin
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (sweep_wr && (sweep_all || !back_sel)) begin
            bank0[sweep_addr] <= CLEAR_VALUE;
        end else if (pix_wr && !back_sel) begin
            bank0[wr_addr] <= data_in;
        end
        if (sweep_wr && (sweep_all || back_sel)) begin
            bank1[sweep_addr] <= CLEAR_VALUE;
        end else if (pix_wr && back_sel) begin
            bank1[wr_addr] <= data_in;
        end
    end

    assign rd_word = front_sel ? bank1[rd_addr] : bank0[rd_addr];
`else
    logic [PIX_W-1:0] bank0 [DEPTH];
    logic             unused_swap_req;

    assign unused_swap_req = swap_req;
    assign front_sel       = 1'b0;

    always_ff @(posedge clock) begin
        if (sweep_wr) begin
            bank0[sweep_addr] <= CLEAR_VALUE;
        end else if (pix_wr) begin
            bank0[wr_addr] <= data_in;
        end
    end

    assign rd_word = bank0[rd_addr];
`endif

    // ------------------------------------------------------------------
    // Registered read port; sees pre-write contents on a same-cycle hit
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= read_enable;
            if (read_enable) begin
                if (busy) begin
                    data_out <= CLEAR_VALUE;
                end else if (!rd_in_range) begin
                    data_out <= BORDER_VALUE;
                end else begin
                    data_out <= rd_word;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scaled_framebuffer.sv
// ============================================================================
// Module      : tb_scaled_framebuffer
// Description : Randomized and directed bench for scaled_framebuffer against
//               a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scaled_framebuffer;

    localparam int H     = 32;
    localparam int V     = 24;
    localparam int N     = H * V;
    localparam int SHIFT = 1;
`ifdef SCALED_FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [7:0]  data_in;
    logic [10:0] data_in_x;
    logic [10:0] data_in_y;
    logic        read_enable;
    logic [10:0] data_out_x;
    logic [10:0] data_out_y;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        clear_req;
    logic        busy;
    logic        swap_req;
    logic        front_sel;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    scaled_framebuffer #(
        .H_RES(H), .V_RES(V), .PIX_W(8), .COORD_W(11), .SCALE_SHIFT(SHIFT),
        .CLEAR_VALUE(8'hFF), .BORDER_VALUE(8'h00)
    ) dut (
        .clock(clock), .reset(reset),
        .write_enable(write_enable), .data_in(data_in),
        .data_in_x(data_in_x), .data_in_y(data_in_y),
        .read_enable(read_enable),
        .data_out_x(data_out_x), .data_out_y(data_out_y),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .clear_req(clear_req), .busy(busy),
        .swap_req(swap_req), .front_sel(front_sel)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: sweep remaining as a plain index, banks as arrays.
    logic [7:0] m_mem [0:1][0:N-1];
    logic [7:0] m_dout;
    bit         m_valid, m_busy, m_all, m_pend;
    int         m_front, m_idx;

    always @(posedge clock) begin
        int sx, sy, back;
        if (!reset) begin
            m_dout = 8'h00; m_valid = 0; m_front = 0; m_pend = 0;
            m_all = 1; m_busy = 1; m_idx = 0;
        end else begin
            back = DBL ? 1 - m_front : 0;
            m_valid = read_enable;
            if (read_enable) begin
                sx = int'(data_out_x) >> SHIFT;
                sy = int'(data_out_y) >> SHIFT;
                if (m_busy)                m_dout = 8'hFF;
                else if (sx >= H || sy >= V) m_dout = 8'h00;
                else                       m_dout = m_mem[m_front][sy * H + sx];
            end
            if (m_busy) begin
                for (int b = 0; b < 2; b++)
                    if (m_all || b == back) m_mem[b][m_idx] = 8'hFF;
                if (swap_req) m_pend = 1;
                m_idx++;
                if (m_idx == N) begin
                    m_busy = 0;
                    m_all  = 0;
                end
            end else begin
                if (write_enable && int'(data_in_x) < H && int'(data_in_y) < V)
                    m_mem[back][int'(data_in_y) * H + int'(data_in_x)] = data_in;
                if (clear_req) begin
                    m_busy = 1;
                    m_idx  = 0;
                end
                if (DBL && (swap_req || m_pend)) begin
                    m_front = 1 - m_front;
                    m_pend  = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            check("busy", busy, m_busy);
            check("valid", data_out_valid, m_valid);
            check("dout", data_out, m_dout);
            check("front", front_sel, m_front);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_write(input int x, input int y, input int v);
        write_enable = 1; data_in_x = 11'(x); data_in_y = 11'(y); data_in = 8'(v);
        tick();
        write_enable = 0;
    endtask

    task automatic do_read(input string tag, input int x, input int y, input int exp);
        read_enable = 1; data_out_x = 11'(x); data_out_y = 11'(y);
        tick();
        read_enable = 0;
        check(tag, data_out, exp);
        check({tag, "_v"}, data_out_valid, 1);
    endtask

    task automatic pulse_clear();
        clear_req = 1;
        tick();
        clear_req = 0;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < N + 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        reset = 0; write_enable = 0; data_in = 0; data_in_x = 0; data_in_y = 0;
        read_enable = 0; data_out_x = 0; data_out_y = 0; clear_req = 0; swap_req = 0;
        repeat (3) tick();
        mon_en = 1;
        check("rst_busy", busy, 1);
        check("rst_dout", data_out, 0);
        tick();
        reset = 1;
        wait_sweep(n);
        check("sweep_len", n, N);
        do_read("rd00", 0, 0, 8'hFF);

`ifdef SCALED_FRAMEBUFFER_DOUBLE_BUFFER_EN
        do_write(0, 0, 8'h11);
        do_read("dbl_back", 0, 0, 8'hFF);
        swap_req = 1;
        tick();
        swap_req = 0;
        check("dbl_front", front_sel, 1);
        do_read("dbl_swap", 0, 0, 8'h11);
`else
        do_write(10, 20, 8'h3C);
        do_read("scale_a", 20, 40, 8'h3C);
        do_read("scale_b", 21, 41, 8'h3C);
        do_write(3, 3, 8'hA5);
        write_enable = 1; data_in_x = 3; data_in_y = 3; data_in = 8'h5A;
        do_read("rbw_old", 6, 6, 8'hA5);
        write_enable = 0;
        do_read("rbw_new", 7, 7, 8'h5A);
`endif
        do_write(H, 5, 8'h55);
        do_read("border", 2 * H, 0, 8'h00);
        do_read("row5", 0, 10, 8'hFF);
        do_read("corner", 2 * H - 1, 2 * V - 1, 8'hFF);
        do_read("border_y", 2 * H - 2, 2 * V, 8'h00);

        // Clear sweep with a dropped write, a busy read and an ignored re-request
        pulse_clear();
        do_write(5, 5, 8'h77);
        do_read("busy_rd", 10, 10, 8'hFF);
        pulse_clear();
        wait_sweep(n);
        check("clr_len", n + 3, N);
        do_read("clr_drop", 10, 10, 8'hFF);
`ifndef SCALED_FRAMEBUFFER_DOUBLE_BUFFER_EN
        do_read("clr_old", 20, 40, 8'hFF);
`endif

        // Reset in the middle of a sweep restarts it from the beginning
        pulse_clear();
        repeat (500) tick();
        reset = 0;
        repeat (2) tick();
        check("rst_front", front_sel, 0);
        reset = 1;
        wait_sweep(n);
        check("rst_sweep", n, N);

        for (int i = 0; i < 3000; i++) begin
            write_enable = 1'($urandom);
            data_in      = 8'($urandom);
            data_in_x    = 11'($urandom_range(0, H + 3));
            data_in_y    = 11'($urandom_range(0, V + 3));
            read_enable  = 1'($urandom);
            data_out_x   = 11'($urandom_range(0, 2 * H + 5));
            data_out_y   = 11'($urandom_range(0, 2 * V + 5));
            swap_req     = ($urandom_range(0, 63) == 0);
            clear_req    = ($urandom_range(0, 1499) == 0);
            tick();
        end
        write_enable = 0; read_enable = 0; swap_req = 0; clear_req = 0;
        wait_sweep(n);
        check("drain", busy, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scaled_framebuffer.md
SCALED_FRAMEBUFFER -- requirements
Module: scaled_framebuffer

Interface
REQ-001 Parameter H_RES, 320, stored frame width in pixels.
REQ-002 Parameter V_RES, 240, stored frame height in pixels.
REQ-003 Parameter PIX_W, 8, pixel word width.
REQ-004 Parameter COORD_W, 11, width of all coordinate ports.
REQ-005 Parameter SCALE_SHIFT, 1, read-side downscale; read coords are right-shifted by this amount.
REQ-006 Parameter CLEAR_VALUE, all-ones, value written by a clear sweep.
REQ-007 Parameter BORDER_VALUE, 0, value returned for out-of-range reads.
REQ-008 clock  input  1  clock; all logic on the rising edge.
REQ-009 reset  input  1  synchronous, active-low reset.
REQ-010 write_enable  input  1  write strobe.
REQ-011 data_in  input  PIX_W  write pixel.
REQ-012 data_in_x / data_in_y  input  COORD_W each  write coordinates in stored-frame space.
REQ-013 read_enable  input  1  read strobe.
REQ-014 data_out_x / data_out_y  input  COORD_W each  read coordinates in display space.
REQ-015 data_out  output  PIX_W  registered read pixel.
REQ-016 data_out_valid  output  1  high for one cycle per accepted read.
REQ-017 clear_req  input  1  single-cycle request for a clear sweep.
REQ-018 busy  output  1  high while a clear sweep is running.
REQ-019 swap_req  input  1  bank swap request.
REQ-020 front_sel  output  1  index of the bank being read.

Function
REQ-021 Storage SHALL hold H_RES*V_RES words per bank, with address y*H_RES+x.
REQ-022 The FSM SHALL have two states: IDLE and CLEAR.
REQ-023 In CLEAR, the block SHALL write CLEAR_VALUE to the sweep address each cycle and increment it; after address H_RES*V_RES-1 it SHALL enter IDLE on the next cycle, for a sweep of exactly H_RES*V_RES cycles.
REQ-024 busy SHALL be 1 exactly while in CLEAR.
REQ-025 In IDLE, clear_req=1 SHALL enter CLEAR with the sweep address at 0 on the next cycle; clear_req while busy SHALL be ignored and SHALL NOT restart the sweep.
REQ-026 A write SHALL occur only when all hold: IDLE, write_enable=1, data_in_x<H_RES, data_in_y<V_RES. All other writes SHALL be silently dropped.
REQ-027 On read_enable=1 at cycle n, sx=data_out_x>>SCALE_SHIFT and sy=data_out_y>>SCALE_SHIFT SHALL be sampled; data_out SHALL be updated and data_out_valid=1 at cycle n+1.
REQ-028 If sx>=H_RES or sy>=V_RES, data_out SHALL be BORDER_VALUE.
REQ-029 Reads accepted while busy SHALL return CLEAR_VALUE.
REQ-030 A same-cycle read and write to the same address SHALL return the old data (read-before-write).
REQ-031 Without read_enable, data_out SHALL hold its value and data_out_valid SHALL be 0.

Reset
REQ-032 While reset=0: data_out=0, data_out_valid=0, front_sel=0, busy=1, sweep address=0, FSM in CLEAR.
REQ-033 After reset releases, a full sweep SHALL run before any write is accepted.
REQ-034 Reset asserted mid-sweep SHALL restart the sweep from address 0.
REQ-035 Memory contents SHALL NOT be reset other than by the sweep.

Configuration
REQ-036 With macro SCALED_FRAMEBUFFER_DOUBLE_BUFFER_EN defined:
  - two banks; reads use bank front_sel; writes and clear_req sweeps target bank ~front_sel
  - the post-reset sweep clears both banks
  - swap_req in IDLE toggles front_sel on the next cycle
  - swap_req while busy SHALL be held pending and applied in the first IDLE cycle
REQ-037 Without SCALED_FRAMEBUFFER_DOUBLE_BUFFER_EN: a single bank serves all reads, writes and sweeps; front_sel SHALL be constant 0; swap_req SHALL be ignored.

Verification
REQ-038 Release reset -> busy=1 for 76800 cycles, then 0; read (0,0) -> data_out=0xFF, data_out_valid=1 one cycle later.
REQ-039 Write (10,20)=0x3C (single bank) -> reads at display (20,40) and (21,41) each return 0x3C with 1-cycle latency.
REQ-040 Write (320,5)=0x55 -> no memory change; read display (640,0) -> 0x00 (BORDER_VALUE).
REQ-041 clear_req after writes -> busy for 76800 cycles; a write during busy is dropped; a read during busy returns 0xFF; after the sweep, the prior location reads 0xFF.
REQ-042 Double-buffer build: write (0,0)=0x11 -> read (0,0) returns 0xFF; pulse swap_req -> front_sel=1 and read (0,0) returns 0x11.
REQ-043 Assert reset at sweep address 1000 -> on release, busy stays high a full 76800 cycles.
